// File: rtl/pll_lock_if.sv
// Control/status bundle between the PLL lock sequencer and its surroundings.
// The sequencer side uses the master modport; the consumer/stimulus side uses slave.
interface pll_lock_if;
    logic       locked;           // raw PLL lock, asynchronous to refclk
    logic       relock_req;       // single-cycle restart request
    logic       pll_rst;          // reset to the PLL
    logic       sys_rst;          // downstream system reset
    logic       ready;            // high only in RUN
    logic       fault;            // high only in FAULT
    logic [3:0] retry_count;      // timeouts in the current sequence
    logic [7:0] lock_loss_count;  // lock losses seen in RUN, saturating
    logic [2:0] state;            // sequencer state encoding

    modport master (
        input  locked, relock_req,
        output pll_rst, sys_rst, ready, fault, retry_count, lock_loss_count, state
    );

    modport slave (
        output locked, relock_req,
        input  pll_rst, sys_rst, ready, fault, retry_count, lock_loss_count, state
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses the PLL reset, waits for a qualified lock,
// holds the system reset until lock has been stable, retries on timeout,
// recovers from lock loss and latches a fault after repeated timeouts.
// Runs entirely in the refclk domain.
module pll_lock_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 20
) (
    input  logic       refclk,
    input  logic       rst,
    pll_lock_if.master bus
);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABILIZE = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    // Terminal counts: each state leaves on the cycle its counter hits N-1,
    // so the state lasts exactly N cycles.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             lock_meta_q, lock_meta_d;
    logic             lock_s_q, lock_s_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;
    logic [3:0]       retry_inc;

    assign retry_inc = retry_q + 4'd1;

    // Two-flop synchronizer inputs for the asynchronous lock signal
    always_comb begin
        lock_meta_d = bus.locked;
        lock_s_d    = lock_meta_q;
    end

    // Next-state, counter and status-counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        case (state_q)
            S_RESET_PLL: begin
                // Lock is not looked at here; the synchronizer just primes.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                cnt_d = cnt_q + 1'b1;
                if (lock_s_q) begin
                    state_d = S_STABILIZE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RETRY_LIMIT) ? S_FAULT : S_RESET_PLL;
                end
            end
            S_STABILIZE: begin
                cnt_d = cnt_q + 1'b1;
                // A single dropped lock sample restarts qualification from
                // WAIT_LOCK with a fresh timeout; it does not count as a retry.
                if (!lock_s_q) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                    retry_d = 4'd0;
                end
            end
            S_RUN: begin
                // Lock loss wins over a simultaneous relock request so it is counted.
                if (!lock_s_q) begin
                    state_d = S_RESET_PLL;
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end
                end else if (bus.relock_req) begin
                    state_d = S_RESET_PLL;
                end
            end
            S_FAULT: begin
                if (bus.relock_req) begin
                    state_d = S_RESET_PLL;
                    retry_d = 4'd0;
                end
            end
            default: begin
                state_d = S_RESET_PLL;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Output decode from the next state so the registered outputs track state_q
    always_comb begin
        pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
        sys_rst_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
        fault_d   = (state_d == S_FAULT);
    end

    // State, counters, synchronizer and output registers
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= S_RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= 4'd0;
            loss_q      <= 8'd0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            lock_meta_q <= lock_meta_d;
            lock_s_q    <= lock_s_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_q   <= sys_rst_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign bus.pll_rst         = pll_rst_q;
    assign bus.sys_rst         = sys_rst_q;
    assign bus.ready           = ready_q;
    assign bus.fault           = fault_q;
    assign bus.retry_count     = retry_q;
    assign bus.lock_loss_count = loss_q;
    assign bus.state           = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer. Expected output vectors are
// pushed into a scoreboard queue, tagged with the cycle they apply to, and
// popped/compared as the run reaches that cycle.
module tb_pll_lock_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   base = 0;
    int   vectors = 0;
    int   miscompares = 0;

    typedef struct {
        string      name;
        int         cyc;
        logic [18:0] val;
    } exp_t;

    exp_t sb[$];

    pll_lock_if bus ();

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES   (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(32),
        .MAX_RETRIES        (2),
        .CNT_W              (20)
    ) dut (
        .refclk(clk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected vector {state, pll_rst, sys_rst, ready, fault, retry_count, lock_loss_count}
    function automatic logic [18:0] ev(input logic [2:0] st, input logic [3:0] rc, input logic [7:0] llc);
        logic pr, sr, rd, ft;
        pr = (st == 3'd0) || (st == 3'd4);
        sr = (st != 3'd3);
        rd = (st == 3'd3);
        ft = (st == 3'd4);
        return {st, pr, sr, rd, ft, rc, llc};
    endfunction

    function automatic logic [18:0] obs_vec();
        return {bus.state, bus.pll_rst, bus.sys_rst, bus.ready, bus.fault,
                bus.retry_count, bus.lock_loss_count};
    endfunction

    task automatic push(input string name, input int k, input logic [2:0] st,
                        input logic [3:0] rc, input logic [7:0] llc);
        exp_t e;
        e.name = name;
        e.cyc  = base + k;
        e.val  = ev(st, rc, llc);
        sb.push_back(e);
    endtask

    task automatic do_reset(input logic lk);
        rst = 1'b1;
        bus.relock_req = 1'b0;
        bus.locked = lk;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        base = cyc;
    endtask

    task automatic test_reset();
        exp_t e;
        do_reset(1'b1);
        push("rst_state", 0, 3'd0, 4'd0, 8'd0);
        push("pll_rst_last", 3, 3'd0, 4'd0, 8'd0);
        push("wait_lock", 4, 3'd1, 4'd0, 8'd0);
        push("stab_first", 5, 3'd2, 4'd0, 8'd0);
        push("stab_last", 12, 3'd2, 4'd0, 8'd0);
        push("run_at_13", 13, 3'd3, 4'd0, 8'd0);
        for (int k = 0; k <= 13; k++) begin
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                vectors++;
                if (obs_vec() !== e.val) begin
                    miscompares++;
                    $display("FAIL %s @%0d: got %h want %h", e.name, cyc - base, obs_vec(), e.val);
                end else
                    $display("ok   %s @%0d: %h", e.name, cyc - base, e.val);
            end
            if (k < 13) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_timeout_fault();
        exp_t e;
        do_reset(1'b0);
        push("to_rst0", 0, 3'd0, 4'd0, 8'd0);
        push("to_rst3", 3, 3'd0, 4'd0, 8'd0);
        push("to_wait1", 4, 3'd1, 4'd0, 8'd0);
        push("to_wait1_end", 35, 3'd1, 4'd0, 8'd0);
        push("to_retry1", 36, 3'd0, 4'd1, 8'd0);
        push("to_retry1_rst", 39, 3'd0, 4'd1, 8'd0);
        push("to_wait2", 40, 3'd1, 4'd1, 8'd0);
        push("to_wait2_end", 71, 3'd1, 4'd1, 8'd0);
        push("to_fault", 72, 3'd4, 4'd2, 8'd0);
        push("fault_hold_lock", 85, 3'd4, 4'd2, 8'd0);
        push("fault_relock", 89, 3'd0, 4'd0, 8'd0);
        push("relock_stab", 101, 3'd2, 4'd0, 8'd0);
        push("relock_run", 102, 3'd3, 4'd0, 8'd0);
        for (int k = 0; k <= 102; k++) begin
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                vectors++;
                if (obs_vec() !== e.val) begin
                    miscompares++;
                    $display("FAIL %s @%0d: got %h want %h", e.name, cyc - base, obs_vec(), e.val);
                end else
                    $display("ok   %s @%0d: %h", e.name, cyc - base, e.val);
            end
            if (k == 75) bus.locked = 1'b1;
            if (k == 88) bus.relock_req = 1'b1;
            if (k == 89) bus.relock_req = 1'b0;
            if (k < 102) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_lock_glitch();
        exp_t e;
        do_reset(1'b1);
        push("gl_stab0", 5, 3'd2, 4'd0, 8'd0);
        push("gl_stab5", 10, 3'd2, 4'd0, 8'd0);
        push("gl_back_wait", 11, 3'd1, 4'd0, 8'd0);
        push("gl_restab", 12, 3'd2, 4'd0, 8'd0);
        push("gl_not_ready", 19, 3'd2, 4'd0, 8'd0);
        push("gl_run", 20, 3'd3, 4'd0, 8'd0);
        for (int k = 0; k <= 20; k++) begin
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                vectors++;
                if (obs_vec() !== e.val) begin
                    miscompares++;
                    $display("FAIL %s @%0d: got %h want %h", e.name, cyc - base, obs_vec(), e.val);
                end else
                    $display("ok   %s @%0d: %h", e.name, cyc - base, e.val);
            end
            if (k == 8) bus.locked = 1'b0;
            if (k == 9) bus.locked = 1'b1;
            if (k < 20) begin
                @(posedge clk); #1;
            end
        end
    endtask

    // Starts in RUN with lock_loss_count = 0 (continues from the glitch test).
    task automatic test_lock_loss();
        exp_t e;
        logic [7:0] llc_old;
        logic [7:0] llc_new;
        llc_new = 8'd0;
        for (int r = 1; r <= 260; r++) begin
            base = cyc;
            llc_old = llc_new;
            llc_new = (llc_old == 8'd255) ? 8'd255 : llc_old + 8'd1;
            push("ll_still_run", 2, 3'd3, 4'd0, llc_old);
            push("ll_sysrst", 3, 3'd0, 4'd0, llc_new);
            push("ll_wait", 7, 3'd1, 4'd0, llc_new);
            push("ll_rerun", 16, 3'd3, 4'd0, llc_new);
            for (int k = 0; k <= 16; k++) begin
                while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                    e = sb.pop_front();
                    vectors++;
                    if (obs_vec() !== e.val) begin
                        miscompares++;
                        $display("FAIL %s r%0d @%0d: got %h want %h", e.name, r, cyc - base, obs_vec(), e.val);
                    end else
                        $display("ok   %s r%0d @%0d: %h", e.name, r, cyc - base, e.val);
                end
                if (k == 0) bus.locked = 1'b0;
                if (k == 1) bus.locked = 1'b1;
                if (k < 16) begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic test_relock();
        exp_t e;
        do_reset(1'b1);
        push("rl_run", 13, 3'd3, 4'd0, 8'd0);
        push("rl_both_run", 16, 3'd3, 4'd0, 8'd0);
        push("rl_both_loss", 17, 3'd0, 4'd0, 8'd1);
        push("rl_both_stab", 29, 3'd2, 4'd0, 8'd1);
        push("rl_both_rerun", 30, 3'd3, 4'd0, 8'd1);
        push("rl_req_run", 31, 3'd3, 4'd0, 8'd1);
        push("rl_req_only", 32, 3'd0, 4'd0, 8'd1);
        push("rl_ign_rstpll", 35, 3'd0, 4'd0, 8'd1);
        push("rl_ign_wait", 36, 3'd1, 4'd0, 8'd1);
        push("rl_ign_wait_nx", 37, 3'd2, 4'd0, 8'd1);
        push("rl_ign_stab", 41, 3'd2, 4'd0, 8'd1);
        push("rl_stab_end", 44, 3'd2, 4'd0, 8'd1);
        push("rl_final_run", 45, 3'd3, 4'd0, 8'd1);
        for (int k = 0; k <= 45; k++) begin
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                vectors++;
                if (obs_vec() !== e.val) begin
                    miscompares++;
                    $display("FAIL %s @%0d: got %h want %h", e.name, cyc - base, obs_vec(), e.val);
                end else
                    $display("ok   %s @%0d: %h", e.name, cyc - base, e.val);
            end
            if (k == 14) bus.locked = 1'b0;
            if (k == 15) bus.locked = 1'b1;
            if (k == 16 || k == 31 || k == 33 || k == 36 || k == 40) bus.relock_req = 1'b1;
            if (k == 17 || k == 32 || k == 34 || k == 37 || k == 41) bus.relock_req = 1'b0;
            if (k < 45) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_rst_priority();
        exp_t e;
        // rst in STABILIZE cycle 3
        do_reset(1'b1);
        push("rp_stab2", 7, 3'd2, 4'd0, 8'd0);
        push("rp_stab3", 8, 3'd2, 4'd0, 8'd0);
        push("rp_rst_stab", 9, 3'd0, 4'd0, 8'd0);
        push("rp_rst_hold", 12, 3'd0, 4'd0, 8'd0);
        push("rp_rst_wait", 13, 3'd1, 4'd0, 8'd0);
        push("rp_rst_run", 22, 3'd3, 4'd0, 8'd0);
        for (int k = 0; k <= 22; k++) begin
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                vectors++;
                if (obs_vec() !== e.val) begin
                    miscompares++;
                    $display("FAIL %s @%0d: got %h want %h", e.name, cyc - base, obs_vec(), e.val);
                end else
                    $display("ok   %s @%0d: %h", e.name, cyc - base, e.val);
            end
            if (k == 8) rst = 1'b1;
            if (k == 9) rst = 1'b0;
            if (k < 22) begin
                @(posedge clk); #1;
            end
        end
        // rst in FAULT with nonzero counters
        do_reset(1'b1);
        push("rf_run", 16, 3'd3, 4'd0, 8'd0);
        push("rf_loss", 17, 3'd0, 4'd0, 8'd1);
        push("rf_wait1_end", 52, 3'd1, 4'd0, 8'd1);
        push("rf_retry1", 53, 3'd0, 4'd1, 8'd1);
        push("rf_wait2_end", 88, 3'd1, 4'd1, 8'd1);
        push("rf_fault", 89, 3'd4, 4'd2, 8'd1);
        push("rf_fault_hold", 92, 3'd4, 4'd2, 8'd1);
        push("rf_rst_fault", 93, 3'd0, 4'd0, 8'd0);
        push("rf_rst_hold", 96, 3'd0, 4'd0, 8'd0);
        push("rf_rst_wait", 97, 3'd1, 4'd0, 8'd0);
        for (int k = 0; k <= 97; k++) begin
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                vectors++;
                if (obs_vec() !== e.val) begin
                    miscompares++;
                    $display("FAIL %s @%0d: got %h want %h", e.name, cyc - base, obs_vec(), e.val);
                end else
                    $display("ok   %s @%0d: %h", e.name, cyc - base, e.val);
            end
            if (k == 14) bus.locked = 1'b0;
            if (k == 92) rst = 1'b1;
            if (k == 93) rst = 1'b0;
            if (k < 97) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        bus.locked = 1'b0;
        bus.relock_req = 1'b0;
        test_reset();
        test_timeout_fault();
        test_lock_glitch();
        test_lock_loss();
        test_relock();
        test_rst_priority();
        if (sb.size() != 0) begin
            $display("FAIL unchecked_expectations: got %0d pending want 0", sb.size());
            miscompares += sb.size();
            vectors += sb.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
